// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell is reused for WIDTH cycles, LSB first,
// with ready/valid handshakes on the command and result sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 partial bits need storing; the last bit comes straight from the adder.
  logic [WIDTH-2:0] s_sh;
  logic             c_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign s_next = {fa_s, s_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c_q     <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            c_q     <= cin;
            bit_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          s_sh    <= s_next[WIDTH-1:1];
          c_q     <= fa_co;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= s_next;
            cout  <= fa_co;
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 directed/random operations
// and an exhaustive back-to-back sweep on a WIDTH=4 instance.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv8, sr8, ci8, rv8, rr8, co8, busy8;
  logic [7:0] a8, b8, s8;
  logic       sv4, sr4, ci4, rv4, rr4, co4, busy4;
  logic [3:0] a4, b4, s4;
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .op_a(a8), .op_b(b8), .cin(ci8), .res_valid(rv8), .res_ready(rr8),
    .sum(s8), .cout(co8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .op_a(a4), .op_b(b4), .cin(ci4), .res_valid(rv4), .res_ready(rr4),
    .sum(s4), .cout(co4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; optionally stalls the consumer and drives stray starts.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int hold, input logic noise);
    logic [8:0] exp;
    int         n;
    logic       ok;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    check("ready8", sr8, 1);
    sv8 = 1'b1; a8 = a; b8 = b; ci8 = c; rr8 = 1'b0;
    step();
    sv8 = noise;
    if (noise) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    end
    n = 0; ok = 1'b1;
    while (!rv8 && n < 40) begin
      if (!busy8 || sr8) ok = 1'b0;
      step();
      n++;
    end
    check("lat8", n, 8);
    check("busy8_run", ok, 1);
    check("res8", {co8, s8}, exp);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if ({co8, s8} !== exp || !rv8 || sr8 || !busy8) ok = 1'b0;
    end
    if (hold > 0) check("bp8_stable", ok, 1);
    rr8 = 1'b1;
    step();
    rr8 = 1'b0; sv8 = 1'b0;
    check("idle8", {rv8, sr8, busy8}, 3'b010);
    step();
    check("nostart8", busy8, 0);
    check("keep8", {co8, s8}, exp);
    $display("txn w8 a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h (hold=%0d)", a, b, c, co8, s8, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic       ok;
    logic [4:0] exp4;
    longint     prev, acc;

    rst_n = 1'b0;
    sv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); rr8 = 1'($urandom);
    sv4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); rr4 = 1'($urandom);
    repeat (3) step();
    check("rst8", {sr8, rv8, busy8, co8, s8}, {3'b100, 1'b0, 8'h00});
    check("rst4", {sr4, rv4, busy4, co4, s4}, {3'b100, 1'b0, 4'h0});
    sv8 = 1'b0; sv4 = 1'b0; rr8 = 1'b0; rr4 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op8(8'h00, 8'h00, 1'b1, 0, 1'b0);
    run_op8(8'hA7, 8'h6E, 1'b1, 5, 1'b1);

    // Abort mid-RUN with an asynchronous reset placed between clock edges.
    sv8 = 1'b1; a8 = 8'h77; b8 = 8'h11; ci8 = 1'b0;
    step();
    sv8 = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst8", {sr8, rv8, busy8, co8, s8}, {3'b100, 1'b0, 8'h00});
    @(negedge clk) rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rv8 || busy8) ok = 1'b0;
    end
    check("abort_novalid8", ok, 1);
    run_op8(8'h12, 8'h34, 1'b0, 0, 1'b0);

    repeat (20) run_op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    // Back-to-back exhaustive sweep on WIDTH=4 with both handshakes held high.
    rr4 = 1'b1; sv4 = 1'b1; prev = 0;
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i); b4 = 4'(i >> 4); ci4 = 1'(i >> 8);
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, ci4};
      n = 0;
      while (!sr4 && n < 20) begin
        step();
        n++;
      end
      step();
      acc = cyc;
      if (i > 0) check("gap4", acc - prev, 6);
      prev = acc;
      n = 0;
      while (!rv4 && n < 20) begin
        step();
        n++;
      end
      check("lat4", n, 4);
      check("res4", {co4, s4}, exp4);
      $display("txn w4 a=%0h b=%0h cin=%0d -> cout=%0d sum=%0h", i & 15, (i >> 4) & 15, i >> 8, co4, s4);
    end
    sv4 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-shares one `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It sequences operand shifting and carry feedback through the single adder cell. It presents ready/valid handshakes on both the command and result sides, so it can sit between a requester and a result consumer wherever area matters more than latency.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  requester has an operation on `op_a`/`op_b`/`cin`.
- `start_ready`  out  1  controller can accept an operation.
- `op_a`  in  WIDTH  addend A; sampled only on the accept edge.
- `op_b`  in  WIDTH  addend B; sampled only on the accept edge.
- `cin`  in  1  carry-in; sampled only on the accept edge.
- `res_valid`  out  1  `sum`/`cout` hold a completed result.
- `res_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  (A + B + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `busy`  out  1  high when not in IDLE.

## Operation
- Contains one `full_adder` instance. Its inputs are `a_sh[0]`, `b_sh[0]` and the carry register `c_q`.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start_ready`=1. On `start_valid & start_ready`, load `a_sh`←`op_a`, `b_sh`←`op_b`, `c_q`←`cin`, `bit_cnt`←0, then go to RUN.
  - RUN: each cycle `a_sh`/`b_sh` shift right by 1, the adder's sum bit shifts into the MSB of `s_sh` (right shift), `c_q`←adder cout, and `bit_cnt`++. When `bit_cnt`==WIDTH-1, load the `sum` register with the final `s_sh` value (including the current bit), load `cout`←adder cout, then go to DONE.
  - DONE: `res_valid`=1. On `res_ready`, go to IDLE.
- `start_ready` and `busy` decode from state: `start_ready` = (state==IDLE), `busy` = !IDLE.
- `start_valid` is ignored outside IDLE. Operand changes after the accept edge have no effect.
- `sum`/`cout` are registered. They update only on the RUN→DONE edge and keep their value through IDLE and the next RUN until the next DONE.
- `bit_cnt` width is $clog2(WIDTH).
- Arithmetic is unsigned. `{cout,sum}` equals `op_a + op_b + cin` as a WIDTH+1-bit value.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed upstream): state=IDLE, `start_ready`=1, `res_valid`=0, `busy`=0, `sum`=0, `cout`=0, all internal registers 0.
- Latency: if accepted at edge E0, RUN occupies edges E1..E_WIDTH and `res_valid` goes high after E_WIDTH. That is exactly WIDTH cycles from accept to valid.
- If `res_ready` is high while `res_valid` is high, the result is consumed at that edge and IDLE is entered. The earliest next accept is the following edge. Best-case throughput is one operation per WIDTH+2 cycles.
- Backpressure: `res_valid`, `sum` and `cout` stay stable while `res_ready`=0, with no limit on duration.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted immediately, outputs go to their reset values, and no `res_valid` is produced for the aborted operation.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `start_ready`=1, `res_valid`=0, `busy`=0, `sum`=0, `cout`=0. Assert reset asynchronously between edges -> outputs change without waiting for a clock edge.
- WIDTH=8, A=0x5A, B=0x3C, cin=0 -> `sum`=0x96, `cout`=0. `res_valid` rises exactly 8 cycles after the accept edge, and `busy` is high for those 8 cycles plus the DONE cycles.
- Carry boundaries (WIDTH=8): 0xFF+0x01, cin=0 -> 0x00 with `cout`=1. 0xFF+0xFF, cin=1 -> 0xFF with `cout`=1. 0x00+0x00, cin=1 -> 0x01 with `cout`=0.
- Backpressure and ignored starts: hold `res_ready`=0 for 5 cycles after `res_valid` rises, and drive `start_valid`=1 with new operands during RUN and DONE -> `start_ready`=0, the result stays stable, and no second operation starts until IDLE.
- Reset mid-operation: pulse `rst_n` low at RUN cycle 3 -> no `res_valid`. A subsequent operation 0x12+0x34 -> 0x46, `cout`=0, with correct latency.
- Back-to-back (WIDTH=4, `res_ready`=1, `start_valid`=1): sweep all 512 (A,B,cin) combinations -> each result matches A+B+cin, and accepts are spaced exactly WIDTH+2=6 cycles apart.
